// File: rtl/priority_demux.sv
// One-to-N stream distributor: routes each accepted word to the lowest-indexed
// requested lane, and counts words that request no lane before discarding them.
module priority_demux #(
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SEL_WIDTH-1:0]            in_sel,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic [SEL_WIDTH-1:0]            out_valid,
    input  logic [SEL_WIDTH-1:0]            out_ready,
    output logic [SEL_WIDTH*DATA_WIDTH-1:0] out_data,
    output logic                            drop_pulse,
    output logic [CNT_WIDTH-1:0]            drop_count
);

    localparam int unsigned BUS_WIDTH = SEL_WIDTH * DATA_WIDTH;

    logic [SEL_WIDTH-1:0] win_oh;
    logic                 none;
    logic                 stall;
    logic                 accept;

    logic [SEL_WIDTH-1:0] valid_q, valid_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 drop_pulse_q, drop_pulse_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    // Isolate the lowest set select bit; in_ready never looks at in_valid.
    always_comb begin
        win_oh   = in_sel & (~in_sel + SEL_WIDTH'(1));
        none     = (in_sel == '0);
        stall    = |(win_oh & valid_q & ~out_ready);
        in_ready = ~stall;
        accept   = in_valid & in_ready;
    end

    always_comb begin
        valid_d      = valid_q & ~out_ready;
        data_d       = data_q;
        drop_pulse_d = accept & none;
        drop_count_d = drop_count_q;
        for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
            if (accept && win_oh[i]) begin
                valid_d[i]                            = 1'b1;
                data_d[i*DATA_WIDTH +: DATA_WIDTH]    = in_data;
            end
        end
        // Saturating count: holds at all-ones rather than wrapping.
        if (accept && none && !(&drop_count_q)) begin
            drop_count_d = drop_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            data_q       <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_priority_demux.sv
// Self-checking bench for priority_demux: directed scenarios plus randomized
// traffic compared against a per-lane occupancy model.
module tb_priority_demux;

    localparam int unsigned SW  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 4;
    localparam int          CMAX = 15;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [SW-1:0]  in_sel;
    logic [DW-1:0]  in_data;
    logic [SW-1:0]  out_valid;
    logic [SW-1:0]  out_ready;
    logic [SW*DW-1:0] out_data;
    logic           drop_pulse;
    logic [CW-1:0]  drop_count;

    priority_demux #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each lane holds at most one word.
    logic [SW-1:0] m_full;
    logic [DW-1:0] m_data [SW];
    int            m_cnt;
    logic          m_pulse;

    logic obs_ready, exp_ready;
    int   n_checks, n_fail;

    function automatic logic [DW-1:0] lane(input int i);
        return out_data[i*DW +: DW];
    endfunction

    function automatic int lowest(input logic [SW-1:0] sel);
        for (int i = 0; i < SW; i++) if (sel[i]) return i;
        return -1;
    endfunction

    function automatic logic model_ready(input logic [SW-1:0] sel, input logic [SW-1:0] rdy);
        int k;
        k = lowest(sel);
        if (k < 0) return 1'b1;
        return !m_full[k] || rdy[k];
    endfunction

    task automatic model_reset();
        m_full  = '0;
        m_cnt   = 0;
        m_pulse = 1'b0;
        for (int i = 0; i < SW; i++) m_data[i] = '0;
    endtask

    // Drive one cycle of inputs, sample in_ready mid-cycle, advance the model at the edge.
    task automatic step(input logic v, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                        input logic [SW-1:0] rdy);
        int  k;
        logic acc;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        #1;
        obs_ready = in_ready;
        exp_ready = model_ready(sel, rdy);
        @(posedge clk);
        acc = v && exp_ready;
        for (int i = 0; i < SW; i++) if (m_full[i] && rdy[i]) m_full[i] = 1'b0;
        m_pulse = acc && (sel == '0);
        if (acc) begin
            k = lowest(sel);
            if (k < 0) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            else begin
                m_full[k] = 1'b1;
                m_data[k] = d;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        model_reset();
        #3;
        n_checks++;
        if (out_valid !== 4'b0000 || drop_pulse !== 1'b0 || drop_count !== 4'd0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_init: out_valid=%b drop_pulse=%b drop_count=%0d required 0000/0/0", out_valid, drop_pulse, drop_count);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 4'b0000, 32'h0, 4'b0000);
        step(1'b1, 4'b0001, 32'h1111_0000, 4'b0000);
        step(1'b1, 4'b0100, 32'h2222_0000, 4'b0000);
        n_checks++;
        if (out_valid !== 4'b0101 || drop_count !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_prefill: out_valid=%b drop_count=%0d required 0101/1", out_valid, drop_count);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 4'b0000 || drop_count !== 4'd0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b drop_count=%0d required 0000/0", out_valid, drop_count);
        end
        #2 rst_n = 1'b1;
        in_valid = 1'b0;
        for (int s = 0; s < 16; s++) begin
            in_sel = 4'(s);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready sel=%b: in_ready=%b required 1", in_sel, in_ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        step(1'b1, 4'b0110, 32'hA5A5_0001, 4'b1111);
        n_checks++;
        if (out_valid !== 4'b0010 || lane(1) !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL priority_0110: out_valid=%b lane1=%h required 0010/a5a50001", out_valid, lane(1));
        end
        step(1'b1, 4'b1000, 32'hA5A5_0002, 4'b1111);
        n_checks++;
        if (out_valid !== 4'b1000 || lane(3) !== 32'hA5A5_0002) begin
            n_fail++;
            $display("FAIL priority_1000: out_valid=%b lane3=%h required 1000/a5a50002", out_valid, lane(3));
        end
        step(1'b0, 4'b0000, 32'h0, 4'b1111);
    endtask

    task automatic test_backpressure();
        step(1'b1, 4'b0001, 32'h11, 4'b1110);
        step(1'b1, 4'b0001, 32'h22, 4'b1110);
        n_checks++;
        if (obs_ready !== 1'b0 || out_valid[0] !== 1'b1 || lane(0) !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b valid0=%b lane0=%h required 0/1/11", obs_ready, out_valid[0], lane(0));
        end
        step(1'b1, 4'b0001, 32'h22, 4'b1111);
        n_checks++;
        if (obs_ready !== 1'b1 || out_valid !== 4'b0001 || lane(0) !== 32'h22) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b lane0=%h required 1/0001/22", obs_ready, out_valid, lane(0));
        end
        step(1'b0, 4'b0000, 32'h0, 4'b1111);
    endtask

    task automatic test_independence();
        step(1'b1, 4'b0001, 32'h44, 4'b1110);
        step(1'b1, 4'b0100, 32'h33, 4'b1110);
        n_checks++;
        if (obs_ready !== 1'b1 || out_valid !== 4'b0101 || lane(2) !== 32'h33 || lane(0) !== 32'h44) begin
            n_fail++;
            $display("FAIL independence: in_ready=%b out_valid=%b lane2=%h lane0=%h required 1/0101/33/44",
                     obs_ready, out_valid, lane(2), lane(0));
        end
        step(1'b0, 4'b0000, 32'h0, 4'b1111);
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL independence_drain: out_valid=%b required 0000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w;
        for (int j = 0; j < 8; j++) begin
            w = 32'hB000_0000 + 32'(j);
            step(1'b1, 4'b1000, w, 4'b1111);
            n_checks++;
            if (obs_ready !== 1'b1 || out_valid !== 4'b1000 || lane(3) !== w) begin
                n_fail++;
                $display("FAIL stream word %0d: in_ready=%b out_valid=%b lane3=%h required 1/1000/%h",
                         j, obs_ready, out_valid, lane(3), w);
            end
        end
        step(1'b0, 4'b0000, 32'h0, 4'b1111);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom(),
                 4'($urandom_range(0, 15)));
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready cyc %0d: in_ready=%b required %b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if (out_valid !== m_full || drop_pulse !== m_pulse || drop_count !== CW'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d: valid=%b pulse=%b cnt=%0d required %b/%b/%0d",
                         c, out_valid, drop_pulse, drop_count, m_full, m_pulse, m_cnt);
            end
            for (int i = 0; i < SW; i++) begin
                if (m_full[i]) begin
                    n_checks++;
                    if (lane(i) !== m_data[i]) begin
                        n_fail++;
                        $display("FAIL rand_data cyc %0d lane %0d: got %h required %h", c, i, lane(i), m_data[i]);
                    end
                end
            end
        end
        step(1'b0, 4'b0000, 32'h0, 4'b1111);
    endtask

    task automatic test_drop();
        rst_n = 1'b0;
        #1 model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 4'b0000, 32'hDEAD_BEEF, 4'b1111);
        n_checks++;
        if (drop_pulse !== 1'b1 || drop_count !== 4'd1 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_single: pulse=%b cnt=%0d valid=%b required 1/1/0000", drop_pulse, drop_count, out_valid);
        end
        step(1'b0, 4'b0000, 32'h0, 4'b1111);
        n_checks++;
        if (drop_pulse !== 1'b0 || drop_count !== 4'd1) begin
            n_fail++;
            $display("FAIL drop_pulse_width: pulse=%b cnt=%0d required 0/1", drop_pulse, drop_count);
        end
        for (int j = 0; j < 20; j++) step(1'b1, 4'b0000, 32'(j), 4'b1111);
        n_checks++;
        if (drop_count !== 4'd15 || drop_count !== CW'(m_cnt)) begin
            n_fail++;
            $display("FAIL drop_saturate: cnt=%0d required 15", drop_count);
        end
        step(1'b1, 4'b0000, 32'h0, 4'b1111);
        n_checks++;
        if (drop_count !== 4'd15 || drop_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_hold: cnt=%0d pulse=%b required 15/1", drop_count, drop_pulse);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_priority();
        test_backpressure();
        test_independence();
        test_back_to_back();
        test_random();
        test_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
